// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit add/subtract evaluated CHUNK bits per clock, with
// the inter-chunk carry held in a register. Valid/ready handshakes on both sides.
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [CHUNK-1:0] w_xc;
  logic [CHUNK-1:0] w_yc;
  logic [CHUNK:0]   w_sum;
  logic             w_last;
  logic             w_accept;
  logic             w_msb_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == LAST);

  assign w_xc  = r_x[r_cnt*CHUNK +: CHUNK];
  assign w_yc  = r_y[r_cnt*CHUNK +: CHUNK];
  assign w_sum = {1'b0, w_xc} + {1'b0, w_yc} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the top bit of the chunk; only meaningful on the final chunk.
  assign w_msb_cin = w_xc[CHUNK-1] ^ w_yc[CHUNK-1] ^ w_sum[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtraction is folded in here: invert y and turn cin into the +1.
      r_x     <= x;
      r_y     <= y ^ {WIDTH{sub}};
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_s[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry                   <= w_sum[CHUNK];
      if (w_last) begin
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_msb_cin ^ w_sum[CHUNK];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s        = r_s;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
